uart_fpga_sw_2_pc: RTL

UART_FPGA_SW_2_PC -- requirements
Module: uart_fpga_sw_2_pc

---
 rtl/uart_fpga_sw_2_pc.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fpga_sw_2_pc.sv
// uart_fpga_sw_2_pc
// Queues the switch byte on each rising edge of the (debounced) send button
// into a small FIFO and transmits queued bytes to the PC as UART frames,
// LSB first, back-to-back while bytes remain queued.
//
// Ports:
//   clk        - system clock, all state on the rising edge
//   reset_n    - asynchronous active-low reset
//   send       - debounced send button (level)
//   sw[7:0]    - switch byte captured on a push
//   tx         - UART line to the PC, idle high, registered
//   busy       - FIFO non-empty or frame in progress
//   fifo_count - bytes queued, excluding the byte in flight
//   overflow   - sticky, a push was dropped because the FIFO was full
//
// Build option: define UART_TX_PARITY_EN for 8E1 frames (even parity bit
// between data and stop); default build sends 8N1.
module uart_fpga_sw_2_pc #(
  parameter int FULL_BAUD = 1302,
  parameter int FIFO_AW   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               send,
  input  logic [7:0]         sw,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (FULL_BAUD > 2) ? $clog2(FULL_BAUD) : 1;

  localparam logic [TW-1:0]      TIMER_MAX  = TW'(FULL_BAUD - 1);
  localparam logic [TW-1:0]      TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0]      TIMER_ONE  = TW'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ZERO   = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO   = FIFO_AW'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t             state_r, state_s;
  logic               send_q_r;
  logic [TW-1:0]      timer_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shift_r;
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]   count_r, count_s;
  logic               overflow_r, busy_r, busy_s, tx_r, tx_s;
  logic               push_ev_s, push_ok_s, drop_s, pop_s, timer_done_s;
`ifdef UART_TX_PARITY_EN
  logic               parity_r;
`endif

  // FIFO control: push/pop decisions and next occupancy.
  always_comb begin
    push_ev_s    = send & ~send_q_r;
    timer_done_s = (timer_r == TIMER_MAX);
    // Pop only from a non-empty FIFO (registered count, so a same-cycle
    // push into an empty FIFO is never bypassed to the shifter).
    if ((count_r != CNT_ZERO) &&
        ((state_r == IDLE) || ((state_r == STOP) && timer_done_s))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    // A full FIFO still accepts the push when a pop frees a slot this edge.
    push_ok_s = push_ev_s & ((count_r != CNT_FULL) | pop_s);
    drop_s    = push_ev_s & ~push_ok_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) state_s = START;
        else       state_s = IDLE;
      end
      START: begin
        if (timer_done_s) state_s = DATA;
        else              state_s = START;
      end
      DATA: begin
        if (timer_done_s && (bit_cnt_r == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_s = PARITY;
`else
          state_s = STOP;
`endif
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (timer_done_s) state_s = STOP;
        else              state_s = PARITY;
      end
`endif
      STOP: begin
        if (timer_done_s) begin
          if (pop_s) state_s = START;
          else       state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM output logic: line level and busy, registered below.
  always_comb begin
    case (state_r)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = parity_r;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (count_s != CNT_ZERO) | (state_s != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Registered outputs; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= busy_s;
    end
  end

  // Button edge detect, FIFO pointers/count, overflow flag, bit timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      send_q_r   <= 1'b1;  // a button held through reset must not push
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
      timer_r    <= TIMER_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      send_q_r <= send;
      count_r  <= count_s;
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (drop_s)    overflow_r <= 1'b1;
      // Every state or bit change happens at expiry, so restarting the
      // timer there gives each bit exactly FULL_BAUD cycles.
      if ((state_r == IDLE) || timer_done_s) timer_r <= TIMER_ZERO;
      else                                   timer_r <= timer_r + TIMER_ONE;
      if (pop_s) begin
        shift_r   <= mem_r[rd_ptr_r];
        bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
        parity_r  <= even_parity(mem_r[rd_ptr_r]);
`endif
      end else if ((state_r == DATA) && timer_done_s) begin
        shift_r   <= {1'b0, shift_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= sw;
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule
